axis_reg_pipe_skid: RTL and testbench
=====================================

Name: axis_reg_pipe_skid

Overview:
- Parametrised successor to the plain AXI-Stream register-slice array.
- Chain of N_STAGES full-throughput skid-buffer stages. Every stage registers tdata, tvalid and tready, so no combinational path crosses the block in either direction.
- Adds sideband pass-through, a live occupancy count and a synchronous flush.
- Inserted on long SLR/floorplan-crossing stream routes in the mlo datapath.

Parameters:
- N_STAGES, 4, number of skid stages; 0 = combinational pass-through.
- DATA_BITS, 32, tdata width (>=1).
- USER_BITS, 1, tuser sideband width (>=1), carried alongside tdata.
- OCC_BITS, $clog2(2*N_STAGES+1) (min 1), occupancy counter width (derived; do not override).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- flush  in  1  synchronous pipeline clear.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  upstream ready.
- s_axis_tdata  in  DATA_BITS  upstream data.
- s_axis_tuser  in  USER_BITS  upstream sideband.
- m_axis_tvalid  out  1  downstream valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  DATA_BITS  downstream data.
- m_axis_tuser  out  USER_BITS  downstream sideband.
- occupancy  out  OCC_BITS  beats currently held, 0..2*N_STAGES.

Behaviour:
- Single clock aclk; reset is synchronous, active-low, on aresetn.
- Reset values:
  - all stage valid/skid-valid flags = 0;
  - occupancy = 0; m_axis_tvalid = 0;
  - s_axis_tready = 1 from the first cycle after reset deasserts;
  - data registers are not reset.
- Per-stage state machine (main register M, skid register K):
  - EMPTY: in_ready=1, out_valid=0. Input beat -> load M -> HALF.
  - HALF: in_ready=1, out_valid=1.
    - Output taken, no input -> EMPTY.
    - Input, no output -> load K -> FULL.
    - Both -> M <= input, stay HALF.
  - FULL: in_ready=0, out_valid=1. Output taken -> M <= K -> HALF.
- in_ready is a registered flag (= !FULL). It must not depend combinationally on out_ready.
- Latency:
  - exactly N_STAGES cycles from s_axis accept to m_axis_tvalid when there is no backpressure;
  - throughput is 1 beat/cycle sustained.
- Capacity: 2*N_STAGES beats. With m_axis_tready held low, s_axis_tready drops after exactly 2*N_STAGES accepted beats.
- Ordering: strict FIFO. tdata/tuser travel as one word and are never reordered or duplicated.
- AXIS rules:
  - once m_axis_tvalid=1 it stays high, with data stable, until m_axis_tready=1;
  - s_axis_tvalid is never required to wait on s_axis_tready.
- occupancy:
  - registered;
  - next = cur + (s_axis_tvalid & s_axis_tready) - (m_axis_tvalid & m_axis_tready);
  - simultaneous in/out leaves it unchanged;
  - never exceeds 2*N_STAGES and never underflows.
- flush (priority below reset, above traffic):
  - in the flush cycle s_axis_tready = 0 combinationally, so no beat is accepted;
  - m_axis may still complete a transfer in that cycle;
  - at the next edge all stages go EMPTY and occupancy = 0;
  - s_axis_tready = 1 the cycle after;
  - flush is legal only at a packet boundary; the system guarantees this.
- Reset mid-stream: all held beats are discarded; m_axis_tvalid = 0 the cycle after the reset edge.
- N_STAGES=0:
  - m_* = s_* and s_axis_tready = m_axis_tready, combinationally;
  - occupancy = 0; flush gates s_axis_tready and m_axis_tvalid low.

Optional Feature:
- Macro AXIS_REG_PIPE_TLAST_EN.
- Defined:
  - adds s_axis_tlast (in, 1) and m_axis_tlast (out, 1), stored in each stage with the data word;
  - adds output pkt_count (16 bits): in-flight packets, i.e. tlast beats held;
  - pkt_count increments on accepted tlast and decrements on emitted tlast;
  - simultaneous accept and emit leaves pkt_count unchanged;
  - pkt_count resets to 0 on aresetn and on flush.
- Undefined: no tlast ports, no pkt_count, no tlast storage.

Test Plan:
- N_STAGES=4, m_axis_tready=1, stream 0x1..0x40 back-to-back -> first m_axis_tvalid 4 cycles after first accept; 64 beats out in 64 consecutive cycles, in order; occupancy steady at 4.
- N_STAGES=4, m_axis_tready=0, s_axis_tvalid=1 continuously -> exactly 8 beats accepted, then s_axis_tready=0 and occupancy=8. Release m_axis_tready -> beats 1..8 emerge in order, then the stream continues without loss.
- Random tvalid/tready (50%/30%), 10000 beats with tuser=data[USER_BITS-1:0] -> scoreboard has zero mismatches; occupancy always equals the model count and is <=8; m_axis data stable while stalled.
- Fill 5 beats with m_axis_tready=0, assert flush 1 cycle -> s_axis_tready=0 in that cycle; occupancy=0 and m_axis_tvalid=0 next cycle; new beat 0xAA then emerges first.
- Reset held low for 1 cycle with occupancy=6 -> m_axis_tvalid=0 and occupancy=0 afterwards; s_axis_tready=1 the following cycle.
- AXIS_REG_PIPE_TLAST_EN defined, 3 packets of 4 beats with m_axis_tready=0 (8 beats accepted, last beats of packets 1 and 2 held) -> pkt_count=2; drain -> m_axis_tlast on beats 4, 8 and 12; pkt_count returns to 0.

Source files
------------

// File: rtl/axis_reg_pipe_skid.sv
// axis_reg_pipe_skid: a chain of N_STAGES full-throughput AXI-Stream skid
// stages. Every stage registers valid, ready and data, so no combinational
// path crosses the block in either direction. The block also carries a tuser
// sideband, keeps a live occupancy count, and supports a synchronous flush.
//
// Optional feature macro: AXIS_REG_PIPE_TLAST_EN
//   When defined, tlast is stored with each beat, and pkt_count tracks how
//   many tlast beats (whole packets) are currently held.

// One skid stage. M holds the beat presented downstream. K catches the single
// beat that was in flight when downstream stalled.
module axis_reg_pipe_skid_stage #(
    parameter int WORD_BITS = 33
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_BITS-1:0] in_word,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_BITS-1:0] out_word
);
    // The state encoding makes out_valid (bit 0) and !in_ready (bit 1) plain flop bits.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        HALF  = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [WORD_BITS-1:0] main_q;
    logic [WORD_BITS-1:0] skid_q;
    logic                 load_main;
    logic                 load_skid;
    logic                 restore_main;

    assign out_valid = state_q[0];
    assign in_ready  = ~state_q[1];
    assign out_word  = main_q;

    // Next state, and which register captures the incoming or held beat.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        restore_main = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_valid) begin
                    load_main = 1'b1;
                    state_d   = HALF;
                end
            end
            HALF: begin
                if (in_valid && out_ready) begin
                    load_main = 1'b1;
                end else if (in_valid) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    restore_main = 1'b1;
                    state_d      = HALF;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State register: reset and flush both empty the stage.
    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop updates from pre-edge values.
        if (!aresetn || flush) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Data registers: M takes the new beat or the skid beat, K takes the overflow beat.
    always_ff @(posedge aclk) begin
        // NOTE: data words are only meaningful while the state marks them valid, so they carry no reset.
        if (load_main) begin
            main_q <= in_word;
        end else if (restore_main) begin
            main_q <= skid_q;
        end
        if (load_skid) begin
            skid_q <= in_word;
        end
    end
endmodule

module axis_reg_pipe_skid #(
    parameter int N_STAGES  = 4,
    parameter int DATA_BITS = 32,
    parameter int USER_BITS = 1,
    parameter int OCC_BITS  = (N_STAGES == 0) ? 1 : $clog2(2 * N_STAGES + 1)
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 flush,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [DATA_BITS-1:0] s_axis_tdata,
    input  logic [USER_BITS-1:0] s_axis_tuser,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic [USER_BITS-1:0] m_axis_tuser,
    output logic [OCC_BITS-1:0]  occupancy
`ifdef AXIS_REG_PIPE_TLAST_EN
    ,
    input  logic                 s_axis_tlast,
    output logic                 m_axis_tlast,
    output logic [15:0]          pkt_count
`endif
);
    // tdata, tuser and, if enabled, tlast travel as one word through the stages.
`ifdef AXIS_REG_PIPE_TLAST_EN
    localparam int WORD_BITS = DATA_BITS + USER_BITS + 1;
`else
    localparam int WORD_BITS = DATA_BITS + USER_BITS;
`endif

    logic [WORD_BITS-1:0] s_word;
    logic [WORD_BITS-1:0] m_word;
    logic                 in_fire;
    logic                 out_fire;

`ifdef AXIS_REG_PIPE_TLAST_EN
    assign s_word = {s_axis_tlast, s_axis_tuser, s_axis_tdata};
    assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = m_word;
`else
    assign s_word = {s_axis_tuser, s_axis_tdata};
    assign {m_axis_tuser, m_axis_tdata} = m_word;
`endif

    assign in_fire  = s_axis_tvalid & s_axis_tready;
    assign out_fire = m_axis_tvalid & m_axis_tready;

    generate
        if (N_STAGES == 0) begin : g_bypass
            // Pure wires. Flush still blocks the handshake in both directions.
            assign m_word        = s_word;
            assign m_axis_tvalid = s_axis_tvalid & ~flush;
            assign s_axis_tready = m_axis_tready & ~flush;
            assign occupancy     = '0;
`ifdef AXIS_REG_PIPE_TLAST_EN
            assign pkt_count     = '0;
`endif
        end else begin : g_pipe
            logic [N_STAGES:0]    chain_valid;
            logic [N_STAGES:0]    chain_ready;
            logic [WORD_BITS-1:0] chain_word [N_STAGES+1];
            logic [OCC_BITS-1:0]  occ_q;

            assign chain_valid[0]        = s_axis_tvalid;
            assign chain_word[0]         = s_word;
            assign chain_ready[N_STAGES] = m_axis_tready;
            assign m_axis_tvalid         = chain_valid[N_STAGES];
            assign m_word                = chain_word[N_STAGES];
            // Ready is a registered flag. Flush gates it so no beat enters a pipe that is being cleared.
            assign s_axis_tready         = chain_ready[0] & ~flush;

            for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
                axis_reg_pipe_skid_stage #(
                    .WORD_BITS(WORD_BITS)
                ) u_stage (
                    .aclk     (aclk),
                    .aresetn  (aresetn),
                    .flush    (flush),
                    .in_valid (chain_valid[i]),
                    .in_ready (chain_ready[i]),
                    .in_word  (chain_word[i]),
                    .out_valid(chain_valid[i+1]),
                    .out_ready(chain_ready[i+1]),
                    .out_word (chain_word[i+1])
                );
            end

            // Occupancy counter: beats accepted minus beats emitted, cleared by reset or flush.
            always_ff @(posedge aclk) begin
                if (!aresetn || flush) begin
                    occ_q <= '0;
                end else if (in_fire && !out_fire) begin
                    occ_q <= occ_q + OCC_BITS'(1);
                end else if (!in_fire && out_fire) begin
                    occ_q <= occ_q - OCC_BITS'(1);
                end
            end
            assign occupancy = occ_q;

`ifdef AXIS_REG_PIPE_TLAST_EN
            logic [15:0] pkt_q;
            logic        last_in;
            logic        last_out;

            assign last_in  = in_fire & s_axis_tlast;
            assign last_out = out_fire & m_axis_tlast;

            // Packet counter: tlast beats accepted minus tlast beats emitted.
            always_ff @(posedge aclk) begin
                if (!aresetn || flush) begin
                    pkt_q <= '0;
                end else if (last_in && !last_out) begin
                    pkt_q <= pkt_q + 16'd1;
                end else if (!last_in && last_out) begin
                    pkt_q <= pkt_q - 16'd1;
                end
            end
            assign pkt_count = pkt_q;
`endif
        end
    endgenerate
endmodule

// File: tb/tb_axis_reg_pipe_skid.sv
// Self-checking bench for axis_reg_pipe_skid (N_STAGES=4). A negedge monitor
// keeps a scoreboard queue plus model occupancy and packet counts. A table of
// per-cycle vectors covers fill and release, and hand-written sequences cover
// latency, flush, reset and random traffic.
`timescale 1ns/1ps
module tb_axis_reg_pipe_skid;
    localparam int N_STAGES  = 4;
    localparam int DATA_BITS = 32;
    localparam int USER_BITS = 1;
    localparam int CAP       = 2 * N_STAGES;
    localparam int OCC_BITS  = $clog2(2 * N_STAGES + 1);
    localparam int WB        = DATA_BITS + USER_BITS;

    logic                 aclk = 1'b0;
    logic                 aresetn;
    logic                 flush;
    logic                 s_axis_tvalid;
    logic                 s_axis_tready;
    logic [DATA_BITS-1:0] s_axis_tdata;
    logic [USER_BITS-1:0] s_axis_tuser;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic [DATA_BITS-1:0] m_axis_tdata;
    logic [USER_BITS-1:0] m_axis_tuser;
    logic [OCC_BITS-1:0]  occupancy;
`ifdef AXIS_REG_PIPE_TLAST_EN
    logic                 s_axis_tlast;
    logic                 m_axis_tlast;
    logic [15:0]          pkt_count;
`endif

    axis_reg_pipe_skid #(
        .N_STAGES (N_STAGES),
        .DATA_BITS(DATA_BITS),
        .USER_BITS(USER_BITS)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .flush        (flush),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tuser (s_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tuser (m_axis_tuser),
        .occupancy    (occupancy)
`ifdef AXIS_REG_PIPE_TLAST_EN
        ,
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tlast (m_axis_tlast),
        .pkt_count    (pkt_count)
`endif
    );

    always #5 aclk = ~aclk;

    int                   n_vec = 0;
    int                   n_fail = 0;
    logic [WB-1:0]        sb_q[$];
    bit                   sb_last[$];
    int                   model_occ = 0;
    int                   model_pkt = 0;
    logic [DATA_BITS-1:0] next_data = 1;
    bit                   mon_en = 0;
    bit                   last_in_fire = 0;
    bit                   prev_stall = 0;
    logic [WB-1:0]        prev_word;
    int                   n_accept = 0;
    int                   n_last_out = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus, driven just after the active edge.
    task automatic cyc(input bit v, input bit r, input bit f);
        @(posedge aclk);
        #1;
        s_axis_tvalid = v;
        m_axis_tready = r;
        flush         = f;
        s_axis_tdata  = next_data;
        s_axis_tuser  = next_data[USER_BITS-1:0];
`ifdef AXIS_REG_PIPE_TLAST_EN
        s_axis_tlast  = (next_data[1:0] == 2'b00);
`endif
    endtask

    task automatic drain();
        int k;
        k = 0;
        cyc(1'b0, 1'b1, 1'b0);
        while ((occupancy != 0 || m_axis_tvalid) && k < 100) begin
            cyc(1'b0, 1'b1, 1'b0);
            k++;
        end
        @(negedge aclk);
        check("drain_occ", occupancy, 0);
        check("drain_sb_empty", sb_q.size(), 0);
    endtask

    // Monitor: scoreboard, model occupancy/packet count, stall stability.
    always @(negedge aclk) begin : monitor
        logic [WB-1:0] got;
        logic [WB-1:0] exp_word;
        bit            exp_last;
        bit            in_f;
        bit            out_f;
        if (mon_en) begin
            got   = {m_axis_tuser, m_axis_tdata};
            in_f  = s_axis_tvalid && s_axis_tready;
            out_f = m_axis_tvalid && m_axis_tready;
            if (prev_stall) begin
                check("stall_valid", m_axis_tvalid, 1);
                check("stall_data", got, prev_word);
            end
            check("occ_model", occupancy, model_occ);
            check("occ_max", occupancy <= CAP, 1);
`ifdef AXIS_REG_PIPE_TLAST_EN
            check("pkt_model", pkt_count, model_pkt);
`endif
            if (out_f) begin
                check("sb_nonempty", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    exp_word = sb_q.pop_front();
                    exp_last = sb_last.pop_front();
                    check("sb_data", got, exp_word);
`ifdef AXIS_REG_PIPE_TLAST_EN
                    check("sb_last", m_axis_tlast, exp_last);
                    if (exp_last) begin
                        n_last_out++;
                    end
                    model_pkt -= int'(exp_last);
`endif
                end
                model_occ--;
            end
            if (in_f) begin
                sb_q.push_back({s_axis_tuser, s_axis_tdata});
`ifdef AXIS_REG_PIPE_TLAST_EN
                sb_last.push_back(s_axis_tlast);
                model_pkt += int'(s_axis_tlast);
`else
                sb_last.push_back(1'b0);
`endif
                model_occ++;
                n_accept++;
                next_data = next_data + 1;
            end
            if (!aresetn || flush) begin
                sb_q.delete();
                sb_last.delete();
                model_occ  = 0;
                model_pkt  = 0;
                prev_stall = 0;
            end else begin
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_word  = got;
            end
            last_in_fire = in_f;
        end
    end

    typedef struct {
        bit v;
        bit r;
        bit f;
        int rdy;
        int mv;
        int occ;
    } vec_t;

    function automatic vec_t mk(bit v, bit r, bit f, int rdy, int mv, int occ);
        vec_t t;
        t = '{v, r, f, rdy, mv, occ};
        return t;
    endfunction

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        vec_t tbl [18];
        int   first_out;
        int   last_out;
        int   n_out;
        int   k;
        int   start;

        // Fill with backpressure, then release: inputs and expected tready/tvalid/occupancy per cycle.
        tbl[0]  = mk(0, 0, 0, 1, 0, 0);
        tbl[1]  = mk(1, 0, 0, 1, 0, 0);
        tbl[2]  = mk(1, 0, 0, 1, 0, 1);
        tbl[3]  = mk(1, 0, 0, 1, 0, 2);
        tbl[4]  = mk(1, 0, 0, 1, 0, 3);
        tbl[5]  = mk(1, 0, 0, 1, 1, 4);
        tbl[6]  = mk(1, 0, 0, 1, 1, 5);
        tbl[7]  = mk(1, 0, 0, 1, 1, 6);
        tbl[8]  = mk(1, 0, 0, 1, 1, 7);
        tbl[9]  = mk(1, 0, 0, 0, 1, 8);
        tbl[10] = mk(1, 0, 0, 0, 1, 8);
        tbl[11] = mk(1, 1, 0, 0, 1, 8);
        tbl[12] = mk(1, 1, 0, 0, 1, 7);
        tbl[13] = mk(1, 1, 0, 0, 1, 6);
        tbl[14] = mk(1, 1, 0, 0, 1, 5);
        tbl[15] = mk(1, 1, 0, 1, 1, 4);
        tbl[16] = mk(1, 1, 0, 1, 1, 4);
        tbl[17] = mk(1, 1, 0, 1, 1, 4);

        aresetn       = 1'b0;
        flush         = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tuser  = '0;
`ifdef AXIS_REG_PIPE_TLAST_EN
        s_axis_tlast  = 1'b0;
`endif
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        mon_en  = 1'b1;
        @(negedge aclk);
        check("reset_mvalid", m_axis_tvalid, 0);
        check("reset_occ", occupancy, 0);
        check("reset_sready", s_axis_tready, 1);

        // Back-to-back stream 0x1..0x40 with no backpressure.
        next_data = 1;
        first_out = -1;
        last_out  = -1;
        n_out     = 0;
        for (int c = 0; c < 80; c++) begin
            cyc(c < 64, 1'b1, 1'b0);
            @(negedge aclk);
            if (c == 0) begin
                check("t1_sready", s_axis_tready, 1);
            end
            if (c == 20) begin
                check("t1_occ_steady", occupancy, N_STAGES);
            end
            if (m_axis_tvalid) begin
                if (first_out < 0) begin
                    first_out = c;
                end
                last_out = c;
                n_out++;
            end
        end
        check("t1_latency", first_out, N_STAGES);
        check("t1_beats", n_out, 64);
        check("t1_contiguous", last_out - first_out + 1, 64);
        drain();

        // Capacity and release, table-driven.
        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].v, tbl[i].r, tbl[i].f);
            @(negedge aclk);
            check($sformatf("tbl%0d_sready", i), s_axis_tready, tbl[i].rdy);
            check($sformatf("tbl%0d_mvalid", i), m_axis_tvalid, tbl[i].mv);
            check($sformatf("tbl%0d_occ", i), occupancy, tbl[i].occ);
        end
        drain();

        // Random valid/ready traffic.
        start = n_accept;
        k     = 0;
        while (n_accept - start < 10000 && k < 60000) begin
            bit v;
            v = (s_axis_tvalid && !last_in_fire) ? 1'b1 : ($urandom_range(0, 99) < 50);
            cyc(v, $urandom_range(0, 99) < 30, 1'b0);
            k++;
        end
        check("rand_beats", n_accept - start >= 10000, 1);
        drain();

        // Flush with 5 beats held.
        repeat (5) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        @(negedge aclk);
        check("flush_sready_low", s_axis_tready, 0);
        check("flush_occ_before", occupancy, 5);
        cyc(1'b0, 1'b0, 1'b0);
        @(negedge aclk);
        check("flush_occ_after", occupancy, 0);
        check("flush_mvalid_after", m_axis_tvalid, 0);
        check("flush_sready_after", s_axis_tready, 1);
        next_data = 'hAA;
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        k = 0;
        while (!m_axis_tvalid && k < 20) begin
            cyc(1'b0, 1'b1, 1'b0);
            k++;
        end
        @(negedge aclk);
        check("flush_first_out", m_axis_tdata, 'hAA);
        drain();

        // Reset mid-stream with 6 beats held.
        repeat (6) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        @(negedge aclk);
        check("rst_occ_before", occupancy, 6);
        cyc(1'b0, 1'b0, 1'b0);
        aresetn = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("rst_mvalid", m_axis_tvalid, 0);
        check("rst_occ", occupancy, 0);
        cyc(1'b0, 1'b0, 1'b0);
        @(negedge aclk);
        check("rst_sready", s_axis_tready, 1);
        drain();

`ifdef AXIS_REG_PIPE_TLAST_EN
        // Three 4-beat packets, held with backpressure and then drained.
        next_data  = 1;
        n_last_out = 0;
        repeat (10) cyc(1'b1, 1'b0, 1'b0);
        @(negedge aclk);
        check("pkt_held_occ", occupancy, CAP);
        check("pkt_held_count", pkt_count, 2);
        repeat (30) cyc(next_data <= 12, 1'b1, 1'b0);
        drain();
        check("pkt_last_beats", n_last_out, 3);
        check("pkt_count_zero", pkt_count, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
